uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in baud.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of 2, at least 2.
REQ-007 SHALL have parameter RTS_THRESHOLD, default FIFO_DEPTH-4, FIFO level at or above which rts deasserts.
REQ-008 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-011 SHALL have port rd_en, input, 1, pop request for one FIFO entry.
REQ-012 SHALL have port rd_data, output, DATA_BITS, popped data word.
REQ-013 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-014 SHALL have port empty, output, 1, FIFO holds zero entries.
REQ-015 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-017 SHALL have port rts, output, 1, flow control; 0 = ready to receive (asserted), 1 = stop sending.
REQ-018 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-019 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.
REQ-020 SHALL have port overrun, output, 1, one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-021 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-022 SHALL use bit period DIV = CLK_FREQ/BAUD_RATE (integer truncation) and a bit counter of width clog2(DIV)+1.
REQ-023 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-024 IDLE: rx_s = 0 SHALL clear the counter and enter START.
REQ-025 START: at count DIV/2, rx_s = 1 SHALL return to IDLE (glitch rejected); rx_s = 0 SHALL enter DATA with the counter cleared.
REQ-026 DATA: each bit SHALL be sampled at count DIV-1, so samples fall at bit centres; bits are shifted in LSB first. After DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
REQ-027 PARITY: one bit SHALL be sampled at bit centre. A mismatch against odd/even parity over the data bits sets a pending-parity-error flag.
REQ-028 STOP: STOP_BITS bits SHALL be sampled at bit centre. Any 0 sample pulses frame_err, discards the word and enters BREAK.
REQ-029 BREAK: SHALL remain in BREAK until rx_s = 1, then enter IDLE.
REQ-030 On the final stop-bit sample cycle N with good stop bits:
- if the parity flag is set, SHALL pulse parity_err in N+1 and discard the word;
- else if the FIFO is full and rd_en is low, SHALL pulse overrun in N+1 and discard the word;
- otherwise SHALL write the word; empty deasserts and level increments in N+1.
- In every case SHALL enter IDLE in N+1.
REQ-031 A frame_err case SHALL NOT also report parity_err; at most one error pulse per frame.
REQ-032 rd_en with empty = 0 SHALL pop the oldest entry; rd_data is updated and rd_valid = 1 in the next cycle only. rd_en with empty = 1 SHALL be ignored: rd_valid stays 0 and rd_data holds.
REQ-033 A write and pop in the same cycle SHALL both occur, leaving level unchanged, including when full.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH. The level bit above the pointer width distinguishes full from empty.
REQ-035 rts SHALL be registered: 1 in the cycle after level >= RTS_THRESHOLD, 0 in the cycle after level < RTS_THRESHOLD.
REQ-036 rd_data SHALL hold its last value until the next successful pop.

Reset
REQ-037 reset = 1 at a clock edge SHALL force state IDLE, counter 0, pointers 0, level 0, empty = 1, full = 0, rd_valid = 0, rd_data = 0, rts = 0, and all error pulses to 0.
REQ-038 reset SHALL also set synchronizer flops to 1.
REQ-039 reset mid-frame SHALL abandon the partial word without writing it or raising an error pulse.
REQ-040 Reception SHALL resume on the first falling edge of rx_s after reset deasserts.

Verification
REQ-041 8N1 at DIV = 104: send 0xA5 -> empty falls about 1000 cycles after the start edge; rd_en -> rd_data = 0xA5, rd_valid for 1 cycle.
REQ-042 PARITY = 2: send 0x03 with parity bit 1 -> parity_err pulses once, level stays 0; a correct frame then reads back 0x03.
REQ-043 Stop bit held 0 for 3 bit times -> frame_err pulses once, nothing written, no new frame until rx returns high.
REQ-044 FIFO_DEPTH = 4, RTS_THRESHOLD = 3: send 5 frames with no reads -> rts = 1 after frame 3, full after frame 4, overrun on frame 5; reads return frames 1-4 in order.
REQ-045 rx low pulse of 20 cycles -> no error pulse, no FIFO write, state back to IDLE.
REQ-046 reset asserted during data bit 4 -> outputs at reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parameterised UART receiver with a receive FIFO and RTS flow control.
// Frames are start bit, DATA_BITS data bits (LSB first), an optional
// odd/even parity bit and STOP_BITS stop bits. Good frames are written to
// the FIFO; bad frames are dropped and reported with a one-cycle error pulse.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   reset      synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   rd_en      pop request for one FIFO entry
//   rd_data    popped data word, holds until the next successful pop
//   rd_valid   one-cycle pulse qualifying rd_data
//   empty      FIFO holds zero entries
//   full       FIFO holds FIFO_DEPTH entries
//   level      current FIFO occupancy
//   rts        0 = ready to receive, 1 = stop sending (registered)
//   frame_err  one-cycle pulse on a bad stop bit
//   parity_err one-cycle pulse on a parity mismatch
//   overrun    one-cycle pulse when a good frame is dropped on a full FIFO
module uart_rx_param #(
    parameter int CLK_FREQ      = 12000000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          rts,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_CNT  = CW'(DIV / 2);
    localparam logic [CW-1:0] CTR_CNT   = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] RTS_LVL   = LW'(RTS_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // True when the received parity bit agrees with the configured mode.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == 1)
            return (^d ^ p) == 1'b1;
        else
            return (^d ^ p) == 1'b0;
    endfunction

    // Line synchronizer
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 stop_idx, stop_n;
    logic                 par_pend, par_n;
    logic                 shift_en;
    logic                 frame_hit;
    logic                 frame_done;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            par_pend <= par_n;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en)
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        bit_n      = bit_idx;
        stop_n     = stop_idx;
        par_n      = par_pend;
        shift_en   = 1'b0;
        frame_hit  = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                bit_n  = '0;
                stop_n = 1'b0;
                par_n  = 1'b0;
                if (!rx_s)
                    state_n = S_START;
            end
            S_START: begin
                // Half a bit into the start bit: a high line means it was a glitch.
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                // Counter restarted at the start-bit centre, so a full period lands mid-bit.
                if (cnt == CTR_CNT) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    bit_n    = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT)
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt == CTR_CNT) begin
                    cnt_n   = '0;
                    state_n = S_STOP;
                    if (!parity_ok(shreg, rx_s))
                        par_n = 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CTR_CNT) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        // A framing error supersedes any pending parity error.
                        frame_hit = 1'b1;
                        state_n   = S_BREAK;
                    end else if (stop_idx == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_n    = S_IDLE;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Receive FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 wr_en;
    logic                 pop;

    assign empty = (level == '0);
    assign full  = (level == DEPTH_LVL);
    // A full FIFO still accepts the word when a pop frees a slot this cycle.
    assign wr_en = frame_done && !par_pend && (!full || rd_en);
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rts        <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            rd_valid   <= pop;
            rts        <= (level >= RTS_LVL);
            frame_err  <= frame_hit;
            parity_err <= frame_done && par_pend;
            overrun    <= frame_done && !par_pend && full && !rd_en;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
// Directed bench for uart_rx_param. Three instances share clock and reset:
//   u_a : 8N1 defaults (DIV = 104, 16-deep FIFO)
//   u_b : 8 data bits, even parity
//   u_c : 8N1 with a 4-deep FIFO and RTS threshold 3
module tb_uart_rx_param;

    localparam int BIT = 104;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rx_a, rx_b, rx_c;
    logic rd_en_a, rd_en_b, rd_en_c;

    logic [7:0] rd_data_a, rd_data_b, rd_data_c;
    logic       rd_valid_a, rd_valid_b, rd_valid_c;
    logic       empty_a, empty_b, empty_c;
    logic       full_a, full_b, full_c;
    logic [4:0] level_a, level_b;
    logic [2:0] level_c;
    logic       rts_a, rts_b, rts_c;
    logic       frame_err_a, frame_err_b, frame_err_c;
    logic       parity_err_a, parity_err_b, parity_err_c;
    logic       overrun_a, overrun_b, overrun_c;

    uart_rx_param u_a (
        .clk(clk), .reset(reset), .rx(rx_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .full(full_a),
        .level(level_a), .rts(rts_a), .frame_err(frame_err_a),
        .parity_err(parity_err_a), .overrun(overrun_a)
    );

    uart_rx_param #(.PARITY(2)) u_b (
        .clk(clk), .reset(reset), .rx(rx_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
        .level(level_b), .rts(rts_b), .frame_err(frame_err_b),
        .parity_err(parity_err_b), .overrun(overrun_b)
    );

    uart_rx_param #(.FIFO_DEPTH(4), .RTS_THRESHOLD(3)) u_c (
        .clk(clk), .reset(reset), .rx(rx_c), .rd_en(rd_en_c),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .empty(empty_c), .full(full_c),
        .level(level_c), .rts(rts_c), .frame_err(frame_err_c),
        .parity_err(parity_err_c), .overrun(overrun_c)
    );

    int tests = 0;
    int fails = 0;

    // Running pulse counts; steps compare deltas across a window.
    int fe_a = 0, pe_a = 0, ov_a = 0;
    int fe_b = 0, pe_b = 0;
    int ov_c = 0, fe_c = 0;

    always @(negedge clk) begin
        if (frame_err_a)  fe_a <= fe_a + 1;
        if (parity_err_a) pe_a <= pe_a + 1;
        if (overrun_a)    ov_a <= ov_a + 1;
        if (frame_err_b)  fe_b <= fe_b + 1;
        if (parity_err_b) pe_b <= pe_b + 1;
        if (overrun_c)    ov_c <= ov_c + 1;
        if (frame_err_c)  fe_c <= fe_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic set_rd(input int sel, input logic v);
        case (sel)
            0:       rd_en_a = v;
            1:       rd_en_b = v;
            default: rd_en_c = v;
        endcase
    endtask

    task automatic get_rd(input int sel, output logic v, output logic [7:0] d);
        case (sel)
            0:       begin v = rd_valid_a; d = rd_data_a; end
            1:       begin v = rd_valid_b; d = rd_data_b; end
            default: begin v = rd_valid_c; d = rd_data_c; end
        endcase
    endtask

    // Drive n line bits, LSB of bits first, one bit period each.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            repeat (BIT) @(negedge clk);
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic send8(input int sel, input logic [7:0] d);
        send_bits(sel, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic sendp(input int sel, input logic [7:0] d, input logic p);
        send_bits(sel, {5'b0, 1'b1, p, d, 1'b0}, 11);
    endtask

    task automatic pop(input int sel, input logic [7:0] exp_d, input string tag);
        logic       v;
        logic [7:0] d;
        set_rd(sel, 1'b1);
        @(negedge clk);
        set_rd(sel, 1'b0);
        get_rd(sel, v, d);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_data"}, 32'(d), 32'(exp_d));
        @(negedge clk);
        get_rd(sel, v, d);
        chk({tag, "_valid_clr"}, 32'(v), 32'd0);
        chk({tag, "_data_hold"}, 32'(d), 32'(exp_d));
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, expected finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s_fe, s_pe, s_ov, s_err;

        reset = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty",    32'(empty_a),    32'd1);
        chk("rst_full",     32'(full_a),     32'd0);
        chk("rst_level",    32'(level_a),    32'd0);
        chk("rst_rts",      32'(rts_a),      32'd0);
        chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("rst_rd_data",  32'(rd_data_a),  32'd0);
        chk("rst_errs",     32'({frame_err_a, parity_err_a, overrun_a}), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: empty falls ~990 cycles after the start edge.
        s_err = fe_a + pe_a + ov_a;
        cyc = 0;
        fork
            send8(0, 8'hA5);
            begin
                while (cyc < 1200 && empty_a) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        chk("a5_latency", 32'(cyc >= 985 && cyc <= 1000), 32'd1);
        chk("a5_level",   32'(level_a), 32'd1);
        chk("a5_no_err",  32'(fe_a + pe_a + ov_a - s_err), 32'd0);
        pop(0, 8'hA5, "a5_pop");
        chk("a5_empty", 32'(empty_a), 32'd1);
        // Pop on empty is ignored.
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
        chk("empty_pop_valid", 32'(rd_valid_a), 32'd0);
        chk("empty_pop_data",  32'(rd_data_a),  32'hA5);
        chk("empty_pop_level", 32'(level_a),    32'd0);

        // Even parity: 0x03 needs parity bit 0; send 1 first.
        s_pe = pe_b;
        s_fe = fe_b;
        sendp(1, 8'h03, 1'b1);
        repeat (5) @(negedge clk);
        chk("par_bad_pulse", 32'(pe_b - s_pe), 32'd1);
        chk("par_bad_level", 32'(level_b), 32'd0);
        chk("par_bad_nofe",  32'(fe_b - s_fe), 32'd0);
        sendp(1, 8'h03, 1'b0);
        chk("par_good_level", 32'(level_b), 32'd1);
        chk("par_good_nope",  32'(pe_b - s_pe), 32'd1);
        pop(1, 8'h03, "par_pop");

        // Stop bit held low for three bit times.
        s_fe = fe_a;
        s_pe = pe_a;
        send_bits(0, 16'h0000, 12);
        set_rx(0, 1'b0);
        chk("brk_fe_low",    32'(fe_a - s_fe), 32'd1);
        chk("brk_level_low", 32'(level_a), 32'd0);
        set_rx(0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        chk("brk_fe_once", 32'(fe_a - s_fe), 32'd1);
        chk("brk_no_pe",   32'(pe_a - s_pe), 32'd0);
        chk("brk_empty",   32'(empty_a), 32'd1);
        send8(0, 8'h3C);
        chk("brk_recover_level", 32'(level_a), 32'd1);
        pop(0, 8'h3C, "brk_pop");

        // Small FIFO: rts, full, overrun, ordering.
        s_ov = ov_c;
        send8(2, 8'h11);
        send8(2, 8'h22);
        chk("fifo2_level", 32'(level_c), 32'd2);
        chk("fifo2_rts",   32'(rts_c),   32'd0);
        send8(2, 8'h33);
        chk("fifo3_level", 32'(level_c), 32'd3);
        chk("fifo3_rts",   32'(rts_c),   32'd1);
        chk("fifo3_full",  32'(full_c),  32'd0);
        send8(2, 8'h44);
        chk("fifo4_level", 32'(level_c), 32'd4);
        chk("fifo4_full",  32'(full_c),  32'd1);
        chk("fifo4_no_ov", 32'(ov_c - s_ov), 32'd0);
        send8(2, 8'h55);
        chk("fifo5_ov",    32'(ov_c - s_ov), 32'd1);
        chk("fifo5_level", 32'(level_c), 32'd4);
        chk("fifo5_no_fe", 32'(fe_c), 32'd0);
        pop(2, 8'h11, "fifo_pop1");
        pop(2, 8'h22, "fifo_pop2");
        pop(2, 8'h33, "fifo_pop3");
        pop(2, 8'h44, "fifo_pop4");
        chk("fifo_empty", 32'(empty_c), 32'd1);
        repeat (2) @(negedge clk);
        chk("fifo_rts_clr", 32'(rts_c), 32'd0);

        // 20-cycle low glitch is rejected.
        s_err = fe_a + pe_a + ov_a;
        set_rx(0, 1'b0);
        repeat (20) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_no_err", 32'(fe_a + pe_a + ov_a - s_err), 32'd0);
        chk("glitch_level",  32'(level_a), 32'd0);
        send8(0, 8'h96);
        chk("glitch_recover_level", 32'(level_a), 32'd1);
        pop(0, 8'h96, "glitch_pop");

        // Reset during data bit 4 of a frame.
        s_err = fe_a + pe_a + ov_a;
        send_bits(0, {7'b0, 8'hC3, 1'b0}, 5);
        set_rx(0, 1'b0);
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        set_rx(0, 1'b1);
        repeat (2) @(negedge clk);
        chk("mrst_empty",    32'(empty_a),    32'd1);
        chk("mrst_level",    32'(level_a),    32'd0);
        chk("mrst_rd_data",  32'(rd_data_a),  32'd0);
        chk("mrst_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("mrst_rts",      32'(rts_a),      32'd0);
        reset = 1'b0;
        repeat (8 * BIT) @(negedge clk);
        chk("mrst_no_write", 32'(level_a), 32'd0);
        chk("mrst_no_err",   32'(fe_a + pe_a + ov_a - s_err), 32'd0);
        send8(0, 8'h5A);
        chk("mrst_recover_level", 32'(level_a), 32'd1);
        pop(0, 8'h5A, "mrst_pop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
